// File: rtl/ring_input_buffer_if.sv
// Bundle of the ring input buffer's handshake, grant and observation signals.
// master: upstream/allocator side driving packets and grants.
// slave : the ring_input_buffer itself.
interface ring_input_buffer_if #(
    parameter int PACKET_SIZE = 49,
    parameter int BUFFER_SIZE = 4
);
    // Upstream ring link
    logic [PACKET_SIZE-1:0]                  ring_in_packet;
    logic                                    ring_in_ready;

    // Local injection port
    logic [PACKET_SIZE-1:0]                  inj_packet;
    logic                                    inj_valid;
    logic                                    inj_ready;

    // Switch allocator grant
    logic [15:0]                             grant_pos;
    logic                                    grant_valid;
    logic                                    grant_in_high;

    // Slot contents and route codes
    logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0] buffer_high_prior;
    logic [BUFFER_SIZE-1:0][1:0]             buffer_high_prior_route_info;
    logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0] buffer_low_prior;
    logic [BUFFER_SIZE-1:0][1:0]             buffer_low_prior_route_info;

    // Acceptance statistics
    logic [31:0]                             ring_accept_cnt;
    logic [31:0]                             inj_accept_cnt;

    modport master (
        output ring_in_packet, inj_packet, inj_valid,
        output grant_pos, grant_valid, grant_in_high,
        input  ring_in_ready, inj_ready,
        input  buffer_high_prior, buffer_high_prior_route_info,
        input  buffer_low_prior, buffer_low_prior_route_info,
        input  ring_accept_cnt, inj_accept_cnt
    );

    modport slave (
        input  ring_in_packet, inj_packet, inj_valid,
        input  grant_pos, grant_valid, grant_in_high,
        output ring_in_ready, inj_ready,
        output buffer_high_prior, buffer_high_prior_route_info,
        output buffer_low_prior, buffer_low_prior_route_info,
        output ring_accept_cnt, inj_accept_cnt
    );
endinterface

// File: rtl/ring_input_buffer.sv
// Ring router input buffer: two slot banks (high = ring traffic, low = local
// injection). Accepted packets land in the lowest free slot of their bank at
// the accepting edge; a grant from the switch allocator frees a slot.
// Packet layout: [48] valid, [47:32] timestamp, [31:16] dest, [15:0] payload.
// Optional feature: define RING_INBUF_STATS_EN to build the 32-bit
// acceptance counters; otherwise both counter outputs are tied to zero.
module ring_input_buffer #(
    parameter logic [15:0] NODE_ID     = 16'd0,
    parameter int          PACKET_SIZE = 49,
    parameter int          BUFFER_SIZE = 4
) (
    input  logic                clk,
    input  logic                rst,
    ring_input_buffer_if.slave  bus
);
    localparam int VALID_BIT = PACKET_SIZE - 1;
    localparam int DEST_HI   = 31;
    localparam int DEST_LO   = 16;

    // Eject when the packet is addressed to this node, else keep circulating.
    function automatic logic [1:0] route_code(input logic [15:0] dest);
        return (dest == NODE_ID) ? 2'b10 : 2'b01;
    endfunction

    logic [15:0]            ts_reg;
    logic [BUFFER_SIZE-1:0] high_occ;
    logic [BUFFER_SIZE-1:0] low_occ;
    logic [BUFFER_SIZE-1:0] high_wr;
    logic [BUFFER_SIZE-1:0] low_wr;
    logic [BUFFER_SIZE-1:0] high_clr;
    logic [BUFFER_SIZE-1:0] low_clr;
    logic                   high_found;
    logic                   low_found;
    logic                   ring_accept;
    logic                   inj_accept;
    logic                   grant_in_range;
    logic [PACKET_SIZE-1:0] inj_word;
    logic [1:0]             ring_route;
    logic [1:0]             inj_route;

    // Injected timestamp field is overwritten, so these input bits are dead.
    logic [PACKET_SIZE-1:DEST_HI+1] unused_inj_bits;
    assign unused_inj_bits = bus.inj_packet[PACKET_SIZE-1:DEST_HI+1];

    // Ready depends only on registered occupancy, so a slot freed by a grant
    // this cycle is not offered until the next one.
    assign bus.ring_in_ready = ~&high_occ;
    assign bus.inj_ready     = ~&low_occ;

    assign ring_accept = bus.ring_in_packet[VALID_BIT] & bus.ring_in_ready;
    assign inj_accept  = bus.inj_valid & bus.inj_ready;

    // Injection is stamped with the local time and always marked valid.
    assign inj_word   = {1'b1, ts_reg, bus.inj_packet[DEST_HI:0]};
    assign ring_route = route_code(bus.ring_in_packet[DEST_HI:DEST_LO]);
    assign inj_route  = route_code(bus.inj_packet[DEST_HI:DEST_LO]);

    // Full 16-bit compare so that out-of-range positions never alias a slot.
    assign grant_in_range = bus.grant_valid && (bus.grant_pos < 16'(BUFFER_SIZE));

    // Free-running timestamp, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_reg <= 16'd0;
        end else begin
            ts_reg <= ts_reg + 16'd1;
        end
    end

    // Pick the lowest-index free slot in each bank for the incoming packet.
    always_comb begin
        high_wr    = '0;
        low_wr     = '0;
        high_found = 1'b0;
        low_found  = 1'b0;
        for (int i = 0; i < BUFFER_SIZE; i++) begin
            if (!high_occ[i] && !high_found) begin
                high_wr[i] = ring_accept;
                high_found = 1'b1;
            end
            if (!low_occ[i] && !low_found) begin
                low_wr[i] = inj_accept;
                low_found = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < BUFFER_SIZE; gi++) begin : g_slot
            logic [PACKET_SIZE-1:0] high_slot_reg;
            logic [PACKET_SIZE-1:0] high_slot_next;
            logic [1:0]             high_route_reg;
            logic [1:0]             high_route_next;
            logic [PACKET_SIZE-1:0] low_slot_reg;
            logic [PACKET_SIZE-1:0] low_slot_next;
            logic [1:0]             low_route_reg;
            logic [1:0]             low_route_next;

            assign high_occ[gi] = high_slot_reg[VALID_BIT];
            assign low_occ[gi]  = low_slot_reg[VALID_BIT];

            // Grants only hit occupied slots; writes only hit free ones.
            assign high_clr[gi] = grant_in_range & bus.grant_in_high
                                & (bus.grant_pos == 16'(gi)) & high_occ[gi];
            assign low_clr[gi]  = grant_in_range & ~bus.grant_in_high
                                & (bus.grant_pos == 16'(gi)) & low_occ[gi];

            // High slot next state: fill from ring, or free on grant.
            always_comb begin
                high_slot_next  = high_slot_reg;
                high_route_next = high_route_reg;
                if (high_wr[gi]) begin
                    high_slot_next  = bus.ring_in_packet;
                    high_route_next = ring_route;
                end else if (high_clr[gi]) begin
                    high_slot_next  = '0;
                    high_route_next = 2'b00;
                end
            end

            // Low slot next state: fill from injection, or free on grant.
            always_comb begin
                low_slot_next  = low_slot_reg;
                low_route_next = low_route_reg;
                if (low_wr[gi]) begin
                    low_slot_next  = inj_word;
                    low_route_next = inj_route;
                end else if (low_clr[gi]) begin
                    low_slot_next  = '0;
                    low_route_next = 2'b00;
                end
            end

            // Slot registers; reset wins over any accept or grant.
            always_ff @(posedge clk) begin
                if (rst) begin
                    high_slot_reg  <= '0;
                    high_route_reg <= 2'b00;
                    low_slot_reg   <= '0;
                    low_route_reg  <= 2'b00;
                end else begin
                    high_slot_reg  <= high_slot_next;
                    high_route_reg <= high_route_next;
                    low_slot_reg   <= low_slot_next;
                    low_route_reg  <= low_route_next;
                end
            end

            assign bus.buffer_high_prior[gi]            = high_slot_reg;
            assign bus.buffer_high_prior_route_info[gi] = high_route_reg;
            assign bus.buffer_low_prior[gi]             = low_slot_reg;
            assign bus.buffer_low_prior_route_info[gi]  = low_route_reg;
        end
    endgenerate

`ifdef RING_INBUF_STATS_EN
    logic [31:0] ring_cnt_reg;
    logic [31:0] inj_cnt_reg;

    // Acceptance counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            ring_cnt_reg <= 32'd0;
            inj_cnt_reg  <= 32'd0;
        end else begin
            if (ring_accept) begin
                ring_cnt_reg <= ring_cnt_reg + 32'd1;
            end
            if (inj_accept) begin
                inj_cnt_reg <= inj_cnt_reg + 32'd1;
            end
        end
    end

    assign bus.ring_accept_cnt = ring_cnt_reg;
    assign bus.inj_accept_cnt  = inj_cnt_reg;
`else
    assign bus.ring_accept_cnt = 32'd0;
    assign bus.inj_accept_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_ring_input_buffer.sv
// Directed bench for ring_input_buffer: reset, injection stamping, ring fill,
// grant/refill ordering, ignored grants, timestamp wrap and statistics.
module tb_ring_input_buffer;
    localparam logic [15:0] NODE = 16'h0003;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] ts = 16'd0;

    logic [48:0] exp_hi [4];
    logic [48:0] exp_lo [4];
    logic [7:0]  exp_hi_rt;
    logic [7:0]  exp_lo_rt;
    logic [31:0] exp_ring_cnt;
    logic [31:0] exp_inj_cnt;

    ring_input_buffer_if #(.PACKET_SIZE(49), .BUFFER_SIZE(4)) bus ();

    ring_input_buffer #(.NODE_ID(NODE), .PACKET_SIZE(49), .BUFFER_SIZE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst) ts = 16'd0;
        else     ts = ts + 16'd1;
    endtask

    task automatic check_bufs(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s hi%0d", tag, i), 64'(bus.buffer_high_prior[i]), 64'(exp_hi[i]));
            chk($sformatf("%s lo%0d", tag, i), 64'(bus.buffer_low_prior[i]), 64'(exp_lo[i]));
        end
        chk({tag, " hi_route"}, 64'(bus.buffer_high_prior_route_info), 64'(exp_hi_rt));
        chk({tag, " lo_route"}, 64'(bus.buffer_low_prior_route_info), 64'(exp_lo_rt));
        $display("step %s: ts=%h ring_ready=%b inj_ready=%b", tag, ts,
                 bus.ring_in_ready, bus.inj_ready);
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 4; i++) begin
            exp_hi[i] = '0;
            exp_lo[i] = '0;
        end
        exp_hi_rt = 8'h00;
        exp_lo_rt = 8'h00;
    endtask

    initial begin
        bus.ring_in_packet = '0;
        bus.inj_packet     = '0;
        bus.inj_valid      = 1'b0;
        bus.grant_pos      = 16'd0;
        bus.grant_valid    = 1'b0;
        bus.grant_in_high  = 1'b0;
        clear_exp();

        // Reset state
        rst = 1'b1;
        step();
        step();
        check_bufs("reset");
        chk("reset ring_cnt", 64'(bus.ring_accept_cnt), 64'd0);
        chk("reset inj_cnt", 64'(bus.inj_accept_cnt), 64'd0);
        rst = 1'b0;
        chk("post_reset ring_ready", 64'(bus.ring_in_ready), 64'd1);
        chk("post_reset inj_ready", 64'(bus.inj_ready), 64'd1);

        // Inject to this node when the timestamp counter reads 5
        repeat (5) step();
        bus.inj_valid  = 1'b1;
        bus.inj_packet = {1'b0, 16'hABCD, NODE, 16'h1234};
        step();
        bus.inj_valid = 1'b0;
        exp_lo[0] = {1'b1, 16'd5, NODE, 16'h1234};
        exp_lo_rt = 8'h02;
        check_bufs("inject_ts5");

        // Four ring packets back to back, all forwarded
        chk("fill ring_ready", 64'(bus.ring_in_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            bus.ring_in_packet = {1'b1, 16'(16'h0100 + k), 16'h0007, 16'(16'h0A00 + k)};
            exp_hi[k] = bus.ring_in_packet;
            step();
        end
        exp_hi_rt = 8'h55;
        check_bufs("ring_fill");
        chk("full ring_ready", 64'(bus.ring_in_ready), 64'd0);

        // Grant slot 2 while a new packet is offered: freed, not yet refilled
        bus.ring_in_packet = {1'b1, 16'h0200, NODE, 16'h0B0B};
        bus.grant_valid    = 1'b1;
        bus.grant_in_high  = 1'b1;
        bus.grant_pos      = 16'd2;
        step();
        bus.grant_valid = 1'b0;
        exp_hi[2] = '0;
        exp_hi_rt = 8'h45;
        check_bufs("grant_hi2");
        chk("freed ring_ready", 64'(bus.ring_in_ready), 64'd1);

        // Held packet now lands in slot 2 with eject route
        step();
        bus.ring_in_packet = '0;
        exp_hi[2] = {1'b1, 16'h0200, NODE, 16'h0B0B};
        exp_hi_rt = 8'h65;
        check_bufs("refill_hi2");
        chk("refill ring_ready", 64'(bus.ring_in_ready), 64'd0);

        // Ignored grants: out of range, empty slot, high bits set
        bus.grant_valid   = 1'b1;
        bus.grant_in_high = 1'b1;
        bus.grant_pos     = 16'd7;
        step();
        check_bufs("grant_pos7");
        bus.grant_in_high = 1'b0;
        bus.grant_pos     = 16'd1;
        step();
        check_bufs("grant_empty_lo1");
        bus.grant_in_high = 1'b1;
        bus.grant_pos     = 16'h0102;
        step();
        check_bufs("grant_pos0102");

        // Grant low slot 0 and inject in the same cycle
        bus.grant_in_high = 1'b0;
        bus.grant_pos     = 16'd0;
        bus.inj_valid     = 1'b1;
        bus.inj_packet    = {1'b1, 16'hFFFF, 16'h0009, 16'h5555};
        exp_lo[1] = {1'b1, ts, 16'h0009, 16'h5555};
        step();
        bus.grant_valid = 1'b0;
        bus.inj_valid   = 1'b0;
        exp_lo[0] = '0;
        exp_lo_rt = 8'h04;
        check_bufs("grant_and_inject");

`ifdef RING_INBUF_STATS_EN
        exp_ring_cnt = 32'd5;
        exp_inj_cnt  = 32'd2;
`else
        exp_ring_cnt = 32'd0;
        exp_inj_cnt  = 32'd0;
`endif
        chk("stats ring_cnt", 64'(bus.ring_accept_cnt), 64'(exp_ring_cnt));
        chk("stats inj_cnt", 64'(bus.inj_accept_cnt), 64'(exp_inj_cnt));

        // Mid-stream reset with traffic and a grant pending
        rst                = 1'b1;
        bus.ring_in_packet = {1'b1, 16'h0300, 16'h0007, 16'h0C0C};
        bus.inj_valid      = 1'b1;
        bus.inj_packet     = {1'b1, 16'h0000, 16'h0007, 16'h0D0D};
        bus.grant_valid    = 1'b1;
        bus.grant_pos      = 16'd1;
        step();
        rst                = 1'b0;
        bus.ring_in_packet = '0;
        bus.inj_valid      = 1'b0;
        bus.grant_valid    = 1'b0;
        clear_exp();
        check_bufs("mid_reset");
        chk("mid_reset ring_cnt", 64'(bus.ring_accept_cnt), 64'd0);
        chk("mid_reset inj_cnt", 64'(bus.inj_accept_cnt), 64'd0);
        chk("mid_reset ring_ready", 64'(bus.ring_in_ready), 64'd1);
        chk("mid_reset inj_ready", 64'(bus.inj_ready), 64'd1);

        // Run the timestamp up to FFFF, then inject on two consecutive cycles
        for (int i = 0; i < 65535; i++) step();
        bus.inj_valid  = 1'b1;
        bus.inj_packet = {1'b0, 16'h1111, 16'h0009, 16'hAAAA};
        step();
        bus.inj_packet = {1'b0, 16'h2222, NODE, 16'hBBBB};
        step();
        bus.inj_valid = 1'b0;
        exp_lo[0] = {1'b1, 16'hFFFF, 16'h0009, 16'hAAAA};
        exp_lo[1] = {1'b1, 16'h0000, NODE, 16'hBBBB};
        exp_lo_rt = 8'h09;
        check_bufs("ts_wrap");
`ifdef RING_INBUF_STATS_EN
        exp_inj_cnt = 32'd2;
`else
        exp_inj_cnt = 32'd0;
`endif
        chk("wrap inj_cnt", 64'(bus.inj_accept_cnt), 64'(exp_inj_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
